// File: rtl/div16u8_restoring_seq_if.sv
// rtl/div16u8_restoring_seq_if.sv - operand/result handshake bundle for the restoring divider
interface div16u8_restoring_seq_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);

  // Operand channel
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;

  // Result channel
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  // Producer of operands / consumer of results
  modport master (
    output in_valid,
    input  in_ready,
    output dividend,
    output divisor,
    input  out_valid,
    output out_ready,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  // The divider itself
  modport slave (
    input  in_valid,
    output in_ready,
    input  dividend,
    input  divisor,
    output out_valid,
    input  out_ready,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/div16u8_restoring_seq.sv
// rtl/div16u8_restoring_seq.sv - radix-2 restoring unsigned divider, one quotient bit per cycle
module div16u8_restoring_seq #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  div16u8_restoring_seq_if.slave bus
);

  // Partial remainder carries one extra bit so the trial compare never overflows.
  localparam int R_W   = DIVISOR_W + 1;
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] qsh_q, qsh_d;     // dividend shifting out / quotient shifting in
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;   // latched divisor
  logic [R_W-1:0]        prem_q, prem_d;   // partial remainder
  logic [CNT_W-1:0]      cnt_q, cnt_d;     // iterations still to run
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [R_W:0]          trial;
  logic                  fits;
  logic [R_W-1:0]        prem_step;
  logic [DIVIDEND_W-1:0] qsh_step;

  // One restoring step: bring down the next dividend bit, subtract if the divisor fits.
  // The top bit of prem_q is always zero between steps, so dropping it on the way back is lossless.
  always_comb begin
    trial = {prem_q, qsh_q[DIVIDEND_W-1]};
    fits  = (trial >= {2'b00, dvsr_q});
    if (fits) begin
      prem_step = R_W'(trial - {2'b00, dvsr_q});
    end else begin
      prem_step = R_W'(trial);
    end
    qsh_step = {qsh_q[DIVIDEND_W-2:0], fits};
  end

  // Next-state and datapath update; every register holds unless its state says otherwise.
  always_comb begin
    state_d = state_q;
    qsh_d   = qsh_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone marks acceptance.
        if (bus.in_valid) begin
          if (bus.divisor != '0) begin
            state_d = BUSY;
            qsh_d   = bus.dividend;
            dvsr_d  = bus.divisor;
            prem_d  = '0;
            cnt_d   = CNT_W'(DIVIDEND_W);
          end else begin
            // Zero divisor short-circuits straight to a flagged, saturated result.
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
          end
        end
      end

      BUSY: begin
        qsh_d  = qsh_step;
        prem_d = prem_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          quot_d  = qsh_step;
          rem_d   = DIVISOR_W'(prem_step);
          dbz_d   = 1'b0;
        end
      end

      DONE: begin
        // Result held until the consumer takes it; no new operand on the same edge.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers, cleared so outputs are never X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qsh_q  <= '0;
      dvsr_q <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      qsh_q  <= qsh_d;
      dvsr_q <= dvsr_d;
      prem_q <= prem_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
